// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for a 2-stage signed 8x8->16 MAC: holds operand vectors A/B,
// streams them into the MAC on start, then presents the result over valid/ready.
module mac_seq_ctrl #(
  parameter int N  = 4,
  parameter int AW = $clog2(N),
  parameter int LW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          start,
  input  logic [LW-1:0] start_len,
  input  logic          abort,
  output logic          busy,
  output logic [7:0]    mac_a,
  output logic [7:0]    mac_b,
  output logic          mac_valid_in,
  output logic          mac_reset,
  input  logic [15:0]   mac_f,
  input  logic          mac_valid_out,
  input  logic          mac_overflow,
  output logic [15:0]   res_data,
  output logic          res_ovf,
  output logic          res_valid,
  input  logic          res_ready
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  localparam logic [LW-1:0] LEN_MAX = LW'(N);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(N);

  state_t        state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] idx_reg, idx_next;
  logic [LW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          ovf_reg, ovf_next;
  logic [LW-1:0] len_clamped;

  logic [7:0]    mac_a_next, mac_b_next;
  logic          mac_valid_in_next, mac_reset_next;
  logic [15:0]   res_data_next;
  logic          res_ovf_next, res_valid_next;

  logic [7:0]    a_buf [N];
  logic [7:0]    b_buf [N];
  logic [N-1:0]  we_a, we_b;
  logic          wr_ok;

  // Buffers only accept host writes while idle, so an in-flight run sees stable operands.
  assign wr_ok = wr_en && (state_reg == IDLE) && ({1'b0, wr_addr} < DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_we
      assign we_a[gi] = wr_ok && !wr_sel && (wr_addr == AW'(gi));
      assign we_b[gi] = wr_ok &&  wr_sel && (wr_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (we_a[i]) a_buf[i] <= wr_data;
        if (we_b[i]) b_buf[i] <= wr_data;
      end
    end
  end

  assign busy        = (state_reg != IDLE);
  assign len_clamped = (start_len > LEN_MAX) ? LEN_MAX : start_len;
  assign cnt_inc     = cnt_reg + LW'(1);

  always_comb begin
    state_next        = state_reg;
    len_next          = len_reg;
    idx_next          = idx_reg;
    cnt_next          = cnt_reg;
    ovf_next          = ovf_reg;
    mac_a_next        = mac_a;
    mac_b_next        = mac_b;
    mac_valid_in_next = 1'b0;
    mac_reset_next    = 1'b0;
    res_data_next     = res_data;
    res_ovf_next      = res_ovf;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          len_next = len_clamped;
          if (len_clamped == '0) begin
            state_next    = DONE;
            res_data_next = '0;
            res_ovf_next  = 1'b0;
          end else begin
            state_next     = CLEAR;
            mac_reset_next = 1'b1;
            mac_a_next     = '0;
            mac_b_next     = '0;
          end
        end
      end
      CLEAR: begin
        state_next        = ISSUE;
        idx_next          = LW'(1);
        cnt_next          = '0;
        ovf_next          = 1'b0;
        mac_valid_in_next = 1'b1;
        mac_a_next        = a_buf[0];
        mac_b_next        = b_buf[0];
      end
      ISSUE, DRAIN: begin
        if (state_reg == ISSUE) begin
          if (idx_reg == len_reg) begin
            state_next = DRAIN;
          end else begin
            mac_valid_in_next = 1'b1;
            mac_a_next        = a_buf[idx_reg[AW-1:0]];
            mac_b_next        = b_buf[idx_reg[AW-1:0]];
            idx_next          = idx_reg + LW'(1);
          end
        end
        // The final overflow is folded in directly since the sticky bit lags a cycle.
        if (mac_valid_out) begin
          cnt_next = cnt_inc;
          ovf_next = ovf_reg | mac_overflow;
          if (cnt_inc == len_reg) begin
            state_next        = DONE;
            res_data_next     = mac_f;
            res_ovf_next      = ovf_reg | mac_overflow;
            mac_valid_in_next = 1'b0;
          end
        end
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (abort && (state_reg != IDLE)) begin
      state_next        = IDLE;
      mac_reset_next    = 1'b1;
      mac_valid_in_next = 1'b0;
      mac_a_next        = '0;
      mac_b_next        = '0;
      res_data_next     = res_data;
      res_ovf_next      = res_ovf;
    end
  end

  assign res_valid_next = (state_next == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      mac_a        <= '0;
      mac_b        <= '0;
      mac_valid_in <= 1'b0;
      mac_reset    <= 1'b1;
      res_data     <= '0;
      res_ovf      <= 1'b0;
      res_valid    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      mac_a        <= mac_a_next;
      mac_b        <= mac_b_next;
      mac_valid_in <= mac_valid_in_next;
      mac_reset    <= mac_reset_next;
      res_data     <= res_data_next;
      res_ovf      <= res_ovf_next;
      res_valid    <= res_valid_next;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural two-stage signed MAC attached.
module tb_mac_seq_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int LW = 3;

  logic          clk;
  logic          reset_n;
  logic          wr_en, wr_sel;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          start;
  logic [LW-1:0] start_len;
  logic          abort;
  logic          busy;
  logic [7:0]    mac_a, mac_b;
  logic          mac_valid_in, mac_reset;
  logic [15:0]   mac_f;
  logic          mac_valid_out, mac_overflow;
  logic [15:0]   res_data;
  logic          res_ovf, res_valid, res_ready;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl #(.N(N), .AW(AW), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_len(start_len), .abort(abort), .busy(busy),
    .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_reset(mac_reset),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out), .mac_overflow(mac_overflow),
    .res_data(res_data), .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC model: stage 1 registers the product, stage 2 accumulates with wrap and flags overflow.
  logic signed [15:0] m_ea, m_eb, m_p, m_f;
  logic signed [16:0] m_sum;
  logic               m_v1, m_vout, m_ovf;

  always_comb begin
    m_ea  = {{8{mac_a[7]}}, mac_a};
    m_eb  = {{8{mac_b[7]}}, mac_b};
    m_sum = {m_f[15], m_f} + {m_p[15], m_p};
  end

  always_ff @(posedge clk) begin
    if (mac_reset) begin
      m_p <= '0; m_f <= '0; m_v1 <= 1'b0; m_vout <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_v1   <= mac_valid_in;
      m_p    <= m_ea * m_eb;
      m_vout <= m_v1;
      if (m_v1) begin
        m_f   <= m_sum[15:0];
        m_ovf <= m_sum[16] ^ m_sum[15];
      end else begin
        m_ovf <= 1'b0;
      end
    end
  end

  assign mac_f         = m_f;
  assign mac_valid_out = m_vout;
  assign mac_overflow  = m_ovf;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [AW-1:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    wr(1'b0, 2'd0, a0); wr(1'b0, 2'd1, a1); wr(1'b0, 2'd2, a2); wr(1'b0, 2'd3, a3);
    wr(1'b1, 2'd0, b0); wr(1'b1, 2'd1, b1); wr(1'b1, 2'd2, b2); wr(1'b1, 2'd3, b3);
  endtask

  // Issue one start, measure cycle numbers relative to the start edge, then accept the result.
  task automatic run(input string tag, input logic [LW-1:0] slen, input logic [15:0] exp_data,
                     input logic exp_ovf, input int exp_cyc, input int exp_vin, input int hold);
    int cyc, vin_cnt, first_vin, last_vin;
    start = 1'b1; start_len = slen;
    tick;
    start = 1'b0;
    cyc = 1; vin_cnt = 0; first_vin = 0; last_vin = 0;
    while (!res_valid && cyc < 60) begin
      if (cyc == 1 && exp_vin > 0) check({tag, " clear_mac_reset"}, {31'b0, mac_reset}, 32'd1);
      if (mac_valid_in) begin
        vin_cnt++;
        if (first_vin == 0) first_vin = cyc;
        last_vin = cyc;
      end
      tick;
      cyc++;
    end
    $display("run %s len=%0d data=%0d ovf=%0d cycle=%0d", tag, slen, $signed(res_data), res_ovf, cyc);
    check({tag, " res_cycle"}, cyc, exp_cyc);
    check({tag, " res_data"}, {16'b0, res_data}, {16'b0, exp_data});
    check({tag, " res_ovf"}, {31'b0, res_ovf}, {31'b0, exp_ovf});
    check({tag, " vin_count"}, vin_cnt, exp_vin);
    if (exp_vin > 0) begin
      check({tag, " vin_first"}, first_vin, 2);
      check({tag, " vin_last"}, last_vin, exp_vin + 1);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; start_len = 3'd1;
      tick;
      check({tag, " hold_valid"}, {31'b0, res_valid}, 32'd1);
      check({tag, " hold_data"}, {16'b0, res_data}, {16'b0, exp_data});
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    check({tag, " valid_drop"}, {31'b0, res_valid}, 32'd0);
    check({tag, " idle_after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int saw;
    reset_n = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_len = '0; abort = 1'b0; res_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst mac_reset", {31'b0, mac_reset}, 32'd1);
    check("rst mac_valid_in", {31'b0, mac_valid_in}, 32'd0);
    check("rst res_valid", {31'b0, res_valid}, 32'd0);
    check("rst res_data", {16'b0, res_data}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("post_rst mac_reset_hold", {31'b0, mac_reset}, 32'd1);
    tick;
    check("post_rst mac_reset_low", {31'b0, mac_reset}, 32'd0);

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run("dot70", 3'd4, 16'd70, 1'b0, 8, 4, 0);

    load(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127);
    run("wrap", 3'd4, 16'hFC04, 1'b1, 8, 4, 0);

    wr(1'b0, 2'd0, 8'hFD); wr(1'b1, 2'd0, 8'd4);
    run("len1", 3'd1, 16'hFFF4, 1'b0, 5, 1, 0);
    wr(1'b0, 2'd1, 8'd2); wr(1'b1, 2'd1, 8'd5);
    run("len2", 3'd2, 16'hFFFE, 1'b0, 6, 2, 0);

    run("len0", 3'd0, 16'd0, 1'b0, 1, 0, 0);

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    run("clamp", 3'd7, 16'd70, 1'b0, 8, 4, 0);

    // Abort in the third cycle after start, with a host write attempted mid-ISSUE.
    start = 1'b1; start_len = 3'd4;
    tick;
    start = 1'b0;
    tick;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd100;
    tick;
    wr_en = 1'b0;
    check("abort pre_issue", {31'b0, mac_valid_in}, 32'd1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort mac_reset", {31'b0, mac_reset}, 32'd1);
    check("abort mac_valid_in", {31'b0, mac_valid_in}, 32'd0);
    tick;
    check("abort mac_reset_pulse", {31'b0, mac_reset}, 32'd0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid) saw = 1;
      tick;
    end
    check("abort no_res_valid", saw, 0);
    run("readback", 3'd4, 16'd70, 1'b0, 8, 4, 0);

    run("hold", 3'd2, 16'd17, 1'b0, 6, 2, 5);

    // Reset while draining; outputs must clear without waiting for a clock edge.
    start = 1'b1; start_len = 3'd4;
    tick;
    start = 1'b0;
    repeat (5) tick;
    check("drain mac_a_held", {24'b0, mac_a}, 32'd4);
    reset_n = 1'b0;
    #1;
    check("drain_rst busy", {31'b0, busy}, 32'd0);
    check("drain_rst mac_reset", {31'b0, mac_reset}, 32'd1);
    check("drain_rst mac_a", {24'b0, mac_a}, 32'd0);
    check("drain_rst res_data", {16'b0, res_data}, 32'd0);
    check("drain_rst res_valid", {31'b0, res_valid}, 32'd0);
    tick;
    reset_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) saw = 1;
      tick;
    end
    check("drain_rst no_res_valid", saw, 0);
    run("cleared_bufs", 3'd4, 16'd0, 1'b0, 8, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
